// File: rtl/cam_pkg.sv
// cam_pkg: shared types, RGB565 field layout and the RGB565->RGB888 expansion for the camera capture path.
package cam_pkg;

  typedef enum logic [1:0] {WAIT_FRAME, BYTE0, BYTE1} cam_state_e;

  localparam int SYNC_STAGES_DEF = 2;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // MSB replication keeps full-scale codes at full scale (0x1F -> 0xFF).
  function automatic rgb888_t rgb565_to_888(input logic [15:0] p);
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5 = p[R_MSB:R_LSB];
    g6 = p[G_MSB:G_LSB];
    b5 = p[B_MSB:B_LSB];
    return '{r: {r5, r5[4:2]}, g: {g6, g6[5:4]}, b: {b5, b5[4:2]}};
  endfunction

endpackage

// File: rtl/cam_capture_if.sv
// cam_capture_if: camera parallel bus in, pixel strobe out; stats ports exist only with CAM_CAPTURE_STATS_EN.
interface cam_capture_if;
  logic       cam_pclk;
  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_d;
  logic [7:0] o_r;
  logic [7:0] o_g;
  logic [7:0] o_b;
  logic       o_valid;
  logic       o_sof;
  logic       o_eol;
`ifdef CAM_CAPTURE_STATS_EN
  logic [15:0] o_frame_cnt;
  logic [0:0]  o_line_err;
`endif

  modport slave (
`ifdef CAM_CAPTURE_STATS_EN
    output o_frame_cnt, o_line_err,
`endif
    input  cam_pclk, cam_vsync, cam_href, cam_d,
    output o_r, o_g, o_b, o_valid, o_sof, o_eol
  );

  modport master (
`ifdef CAM_CAPTURE_STATS_EN
    input  o_frame_cnt, o_line_err,
`endif
    output cam_pclk, cam_vsync, cam_href, cam_d,
    input  o_r, o_g, o_b, o_valid, o_sof, o_eol
  );
endinterface

// File: rtl/cam_sync.sv
// cam_sync: N-stage synchronizer for one asynchronous bit with rise/fall detect on the synchronized value.
module cam_sync #(
  parameter int N = 2
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [N-1:0] sync_q;
  logic         prev_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
      prev_q <= sync_q[N-1];
    end
  end

  always_comb begin
    q_o    = sync_q[N-1];
    rise_o = sync_q[N-1] & ~prev_q;
    fall_o = ~sync_q[N-1] & prev_q;
  end
endmodule

// File: rtl/cam_capture.sv
// cam_capture: oversamples the PMOD camera bus in aclk, pairs RGB565 bytes, emits RGB888 strobes with sof/eol.
// Optional CAM_CAPTURE_STATS_EN adds a frame counter and a sticky line-length error flag.
module cam_capture
  import cam_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int HI_FIRST    = 1,
  parameter int VSYNC_POL   = 1
) (
  input  logic          aclk,
  input  logic          aresetn,
  cam_capture_if.slave  bus
);
  logic pclk_s, pclk_rise, pclk_fall;
  logic href_s, href_rise, href_fall;
  logic vs_s, vs_rise, vs_fall;
  logic unused_sync;

  cam_sync #(.N(SYNC_STAGES)) u_pclk (
    .aclk(aclk), .aresetn(aresetn), .d_i(bus.cam_pclk),
    .q_o(pclk_s), .rise_o(pclk_rise), .fall_o(pclk_fall)
  );
  cam_sync #(.N(SYNC_STAGES)) u_href (
    .aclk(aclk), .aresetn(aresetn), .d_i(bus.cam_href),
    .q_o(href_s), .rise_o(href_rise), .fall_o(href_fall)
  );
  cam_sync #(.N(SYNC_STAGES)) u_vsync (
    .aclk(aclk), .aresetn(aresetn), .d_i(bus.cam_vsync),
    .q_o(vs_s), .rise_o(vs_rise), .fall_o(vs_fall)
  );

  // Data needs no edge detect, only the same depth so it lines up with pclk/href.
  logic [SYNC_STAGES-1:0][7:0] d_sync_q;
  logic [7:0]                  d_s;

  always_ff @(posedge aclk) begin
    if (!aresetn) d_sync_q <= '0;
    else d_sync_q <= {d_sync_q[SYNC_STAGES-2:0], bus.cam_d};
  end

  cam_state_e state_q;
  logic       armed_q, sof_pend_q, hold_full_q;
  logic [7:0] byte0_q;
  rgb888_t    hold_q, pix_q;
  logic       valid_q, sof_q, eol_q;

  logic       vs_act, vs_deact, in_frame, byte_ok, pair_done, new_frame, emit_d;
  logic [15:0] pair_d;
  rgb888_t    pix_d;

  always_comb begin
    d_s         = d_sync_q[SYNC_STAGES-1];
    unused_sync = ^{pclk_s, pclk_fall, href_rise, vs_s};
    vs_act      = (VSYNC_POL != 0) ? vs_rise : vs_fall;
    vs_deact    = (VSYNC_POL != 0) ? vs_fall : vs_rise;
    in_frame    = state_q != WAIT_FRAME;
    byte_ok     = pclk_rise & href_s;
    pair_done   = byte_ok & (state_q == BYTE1);
    new_frame   = in_frame ? vs_act : (vs_deact & armed_q);
    emit_d      = in_frame & ~vs_act & hold_full_q & (href_fall | pair_done);
    pair_d      = (HI_FIRST != 0) ? {byte0_q, d_s} : {d_s, byte0_q};
    pix_d       = rgb565_to_888(pair_d);
  end

  // vsync beats href fall beats byte capture; emission never coincides with vsync so sof_pend writes are exclusive.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= WAIT_FRAME;
      armed_q     <= 1'b0;
      sof_pend_q  <= 1'b0;
      hold_full_q <= 1'b0;
      byte0_q     <= '0;
      hold_q      <= '0;
      pix_q       <= '0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
    end else begin
      valid_q <= emit_d;
      sof_q   <= emit_d & sof_pend_q;
      eol_q   <= emit_d & href_fall;
      if (emit_d) begin
        pix_q      <= hold_q;
        sof_pend_q <= 1'b0;
      end
      if (new_frame) sof_pend_q <= 1'b1;
      if (!in_frame) begin
        armed_q <= vs_act | (armed_q & ~vs_deact);
        if (new_frame) state_q <= BYTE0;
      end else if (vs_act | href_fall) begin
        state_q     <= BYTE0;
        hold_full_q <= 1'b0;
      end else if (byte_ok) begin
        state_q <= (state_q == BYTE0) ? BYTE1 : BYTE0;
        if (state_q == BYTE0) byte0_q <= d_s;
        else begin
          hold_q      <= pix_d;
          hold_full_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.o_r     = pix_q.r;
    bus.o_g     = pix_q.g;
    bus.o_b     = pix_q.b;
    bus.o_valid = valid_q;
    bus.o_sof   = sof_q;
    bus.o_eol   = eol_q;
  end

`ifdef CAM_CAPTURE_STATS_EN
  logic [15:0] frame_cnt_q, pix_cnt_q, ref_cnt_q;
  logic        line_err_q, first_line_q;

  // Lines with no completed pixel (e.g. href falling right after a mid-line vsync) are not measured.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      frame_cnt_q  <= '0;
      pix_cnt_q    <= '0;
      ref_cnt_q    <= '0;
      line_err_q   <= 1'b0;
      first_line_q <= 1'b0;
    end else begin
      if (emit_d & sof_pend_q) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (new_frame) begin
        pix_cnt_q    <= '0;
        first_line_q <= 1'b1;
      end else if (in_frame & href_fall) begin
        pix_cnt_q <= '0;
        if (state_q == BYTE1 || (!first_line_q && pix_cnt_q != 16'd0 && pix_cnt_q != ref_cnt_q))
          line_err_q <= 1'b1;
        if (first_line_q && pix_cnt_q != 16'd0) begin
          ref_cnt_q    <= pix_cnt_q;
          first_line_q <= 1'b0;
        end
      end else if (pair_done) pix_cnt_q <= pix_cnt_q + 16'd1;
    end
  end

  always_comb begin
    bus.o_frame_cnt = frame_cnt_q;
    bus.o_line_err  = line_err_q;
  end
`endif

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: table-driven stimulus with a pixel scoreboard for cam_capture.
module tb_cam_capture;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;

  cam_capture_if bus();
  cam_capture dut (.aclk(aclk), .aresetn(aresetn), .bus(bus));

  always #5 aclk = ~aclk;

  typedef struct {
    logic [7:0] r, g, b;
    logic       sof, eol;
  } exp_t;

  typedef struct {
    logic [15:0] pix;
    logic [7:0]  r, g, b;
  } vec_t;

  exp_t sb[$];
  vec_t tab[8];
  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int sofcnt = 0;
  int eolcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mdl(input logic [15:0] p, input logic s, input logic e);
    logic [7:0] r5, g6, b5;
    r5 = 8'(p[15:11]);
    g6 = 8'(p[10:5]);
    b5 = 8'(p[4:0]);
    mdl.r = (r5 << 3) | (r5 >> 2);
    mdl.g = (g6 << 2) | (g6 >> 4);
    mdl.b = (b5 << 3) | (b5 >> 2);
    mdl.sof = s;
    mdl.eol = e;
  endfunction

  task automatic mon_step();
    exp_t e;
    chk("strobe_without_valid", 64'(!bus.o_valid && (bus.o_sof || bus.o_eol)), 64'd0);
    if (bus.o_valid) begin
      vcnt++;
      sofcnt += int'(bus.o_sof);
      eolcnt += int'(bus.o_eol);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel: got %h%h%h sof=%b eol=%b, expected no strobe",
                 bus.o_r, bus.o_g, bus.o_b, bus.o_sof, bus.o_eol);
      end else begin
        e = sb.pop_front();
        chk("pixel", 64'({bus.o_r, bus.o_g, bus.o_b, bus.o_sof, bus.o_eol}),
            64'({e.r, e.g, e.b, e.sof, e.eol}));
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.cam_d = b;
    bus.cam_href = 1'b1;
    tick(4);
    bus.cam_pclk = 1'b1;
    tick(4);
    bus.cam_pclk = 1'b0;
  endtask

  task automatic send_px(input logic [15:0] p);
    send_byte(p[15:8]);
    send_byte(p[7:0]);
  endtask

  task automatic end_line();
    bus.cam_href = 1'b0;
    bus.cam_d = 8'h00;
    tick(12);
  endtask

  task automatic vsync_pulse();
    bus.cam_vsync = 1'b1;
    tick(16);
    bus.cam_vsync = 1'b0;
    tick(16);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    chk(name, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic check_zero(input string name);
    chk({name, "_rgb"}, 64'({bus.o_r, bus.o_g, bus.o_b}), 64'd0);
    chk({name, "_valid"}, 64'(bus.o_valid), 64'd0);
    chk({name, "_sof"}, 64'(bus.o_sof), 64'd0);
    chk({name, "_eol"}, 64'(bus.o_eol), 64'd0);
`ifdef CAM_CAPTURE_STATS_EN
    chk({name, "_frame_cnt"}, 64'(bus.o_frame_cnt), 64'd0);
    chk({name, "_line_err"}, 64'(bus.o_line_err), 64'd0);
`endif
  endtask

  initial begin
    int v0;
    logic [15:0] p;
    tab[0] = '{16'hF800, 8'hFF, 8'h00, 8'h00};
    tab[1] = '{16'h07E0, 8'h00, 8'hFF, 8'h00};
    tab[2] = '{16'h001F, 8'h00, 8'h00, 8'hFF};
    tab[3] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF};
    tab[4] = '{16'h8410, 8'h84, 8'h82, 8'h84};
    tab[5] = '{16'h1234, 8'h10, 8'h45, 8'hA5};
    tab[6] = '{16'hA5A5, 8'hA5, 8'hB6, 8'h29};
    tab[7] = '{16'h0841, 8'h08, 8'h08, 8'h08};
    bus.cam_pclk = 1'b0;
    bus.cam_vsync = 1'b0;
    bus.cam_href = 1'b0;
    bus.cam_d = 8'h00;
    tick(4);
    check_zero("reset");
    fork
      forever begin
        @(negedge aclk);
        mon_step();
      end
    join_none
    aresetn = 1'b1;
    tick(4);

    // bytes before any vsync are ignored
    v0 = vcnt;
    for (int i = 0; i < 3; i++) send_px(tab[i].pix);
    end_line();
    chk("no_vsync_silent", 64'(vcnt - v0), 64'd0);

    // first line of a frame: sof on first, eol on last
    vsync_pulse();
    for (int i = 0; i < 4; i++) sb.push_back('{tab[i].r, tab[i].g, tab[i].b, i == 0, i == 3});
    for (int i = 0; i < 4; i++) send_px(tab[i].pix);
    end_line();
    drain("line_basic");
`ifdef CAM_CAPTURE_STATS_EN
    chk("line_err_clean", 64'(bus.o_line_err), 64'd0);
`endif

    // trailing odd byte is dropped
    for (int i = 0; i < 4; i++) sb.push_back('{tab[i].r, tab[i].g, tab[i].b, 1'b0, i == 3});
    for (int i = 0; i < 4; i++) send_px(tab[i].pix);
    send_byte(8'hAA);
    end_line();
    drain("line_odd_byte");
`ifdef CAM_CAPTURE_STATS_EN
    chk("line_err_partial", 64'(bus.o_line_err), 64'd1);
`endif

    // vsync mid-line drops the held pixel without eol
    sb.push_back('{tab[4].r, tab[4].g, tab[4].b, 1'b0, 1'b0});
    send_px(tab[4].pix);
    send_px(tab[5].pix);
    tick(4);
    drain("midline_first");
    v0 = vcnt;
    bus.cam_vsync = 1'b1;
    tick(16);
    bus.cam_href = 1'b0;
    tick(16);
    bus.cam_vsync = 1'b0;
    tick(16);
    chk("midline_dropped", 64'(vcnt - v0), 64'd0);
    for (int i = 4; i < 8; i++) sb.push_back('{tab[i].r, tab[i].g, tab[i].b, i == 4, i == 7});
    for (int i = 4; i < 8; i++) send_px(tab[i].pix);
    end_line();
    drain("after_midline_vsync");

    // one-cycle reset mid-line silences output until the next vsync
    sb.push_back('{tab[0].r, tab[0].g, tab[0].b, 1'b0, 1'b0});
    send_px(tab[0].pix);
    send_px(tab[1].pix);
    tick(4);
    drain("pre_reset");
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    check_zero("midline_reset");
    aresetn = 1'b1;
    v0 = vcnt;
    send_px(tab[2].pix);
    send_px(tab[3].pix);
    end_line();
    chk("post_reset_silent", 64'(vcnt - v0), 64'd0);
    vsync_pulse();
    sb.push_back('{tab[1].r, tab[1].g, tab[1].b, 1'b1, 1'b0});
    sb.push_back('{tab[2].r, tab[2].g, tab[2].b, 1'b0, 1'b1});
    send_px(tab[1].pix);
    send_px(tab[2].pix);
    end_line();
    drain("post_reset_frame");

    // two frames of 2 lines x 3 random pixels
    aresetn = 1'b0;
    tick(3);
    aresetn = 1'b1;
    tick(2);
    sofcnt = 0;
    eolcnt = 0;
    for (int f = 0; f < 2; f++) begin
      vsync_pulse();
      for (int l = 0; l < 2; l++) begin
        for (int k = 0; k < 3; k++) begin
          p = 16'($urandom);
          sb.push_back(mdl(p, l == 0 && k == 0, k == 2));
          send_px(p);
        end
        end_line();
      end
    end
    drain("two_frames");
    chk("sof_count", 64'(sofcnt), 64'd2);
    chk("eol_count", 64'(eolcnt), 64'd4);
`ifdef CAM_CAPTURE_STATS_EN
    chk("frame_cnt", 64'(bus.o_frame_cnt), 64'd2);
    chk("line_err_two_frames", 64'(bus.o_line_err), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
